// File: rtl/uart_pkg.sv
// Shared UART receiver constants, the sampler window state type and small
// helper functions.
package uart_pkg;

  localparam int unsigned UART_EDGE_W  = 6;
  localparam int unsigned PRESCALE_MIN = 4;
  localparam int unsigned PRESCALE_8   = 8;
  localparam int unsigned PRESCALE_16  = 16;
  localparam int unsigned PRESCALE_32  = 32;

  typedef enum logic {
    WIN_IDLE   = 1'b0,
    WIN_ACTIVE = 1'b1
  } win_state_t;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // A bit is voted 1 when its count of ones is strictly above this value.
  function automatic int unsigned vote_threshold(input int unsigned nsamp);
    return (nsamp - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_majority_acc.sv
// Ones counter and unanimity tracker for one majority-vote window; the
// vote and unanimity outputs already include the current input sample.
module uart_majority_acc
  import uart_pkg::*;
#(
  parameter int unsigned NSAMP = 3
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clr,
  input  logic start,
  input  logic add,
  input  logic din,
  output logic vote_c,
  output logic unanimous_c
);

  localparam int unsigned CW   = (clog2(NSAMP + 1) > 0) ? clog2(NSAMP + 1) : 1;
  localparam int unsigned HALF = vote_threshold(NSAMP);

  logic [CW-1:0] ones_cnt;
  logic          seen0;
  logic          seen1;
  logic [CW-1:0] sum_c;

  // A start in the same cycle as a commit means a single-sample window.
  always_comb begin
    sum_c       = (start ? CW'(0) : ones_cnt) + CW'(din);
    vote_c      = (sum_c > CW'(HALF));
    unanimous_c = start ? 1'b1 : (din ? ~seen0 : ~seen1);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ones_cnt <= '0;
      seen0    <= 1'b0;
      seen1    <= 1'b0;
    end else if (clr) begin
      ones_cnt <= '0;
      seen0    <= 1'b0;
      seen1    <= 1'b0;
    end else if (start) begin
      ones_cnt <= CW'(din);
      seen1    <= din;
      seen0    <= ~din;
    end else if (add) begin
      ones_cnt <= ones_cnt + CW'(din);
      seen1    <= seen1 | din;
      seen0    <= seen0 | ~din;
    end
  end

endmodule

// File: rtl/uart_rx_oversampler.sv
// Majority-vote bit sampler: votes NSAMP oversampled ticks centred on mid-bit
// and flags non-unanimous votes and illegal prescale/NSAMP combinations.
module uart_rx_oversampler
  import uart_pkg::*;
#(
  parameter int unsigned EDGE_W = UART_EDGE_W,
  parameter int unsigned NSAMP  = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              rx_in,
  input  logic              samp_en,
  input  logic [EDGE_W-1:0] prescale,
  input  logic [EDGE_W-1:0] edge_cnt,
  output logic              sampled_bit,
  output logic              bit_valid,
  output logic              noise_flag,
  output logic              cfg_err
);

  localparam int unsigned HALF = vote_threshold(NSAMP);
  localparam int unsigned SW   = EDGE_W + 1;

  win_state_t    state;
  win_state_t    state_nxt;
  logic [SW-1:0] s_val;
  logic [SW-1:0] e_val;
  logic [SW-1:0] edge_ext;
  logic          cfg_err_c;
  logic          cfg_bad_c;
  logic          at_s_c;
  logic          at_e_c;
  logic          in_mid_c;
  logic          acc_clr_c;
  logic          acc_start_c;
  logic          acc_add_c;
  logic          acc_commit_c;
  logic          vote_c;
  logic          unanimous_c;

  // Window bounds carry one extra bit so an underflowing start is visible.
  always_comb begin
    s_val     = SW'(prescale >> 1) - SW'(HALF);
    e_val     = s_val + SW'(NSAMP - 1);
    edge_ext  = SW'(edge_cnt);
    cfg_err_c = (prescale < EDGE_W'(PRESCALE_MIN)) | prescale[0] | s_val[SW-1] |
                (e_val >= SW'(prescale));
    cfg_bad_c = cfg_err_c | cfg_err;
    at_s_c    = (edge_ext == s_val);
    at_e_c    = (edge_ext == e_val);
    in_mid_c  = (edge_ext > s_val) && (edge_ext < e_val);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= WIN_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!samp_en) begin
      state_nxt = WIN_IDLE;
    end else if (!cfg_bad_c) begin
      if (at_s_c && at_e_c)                  state_nxt = WIN_IDLE;
      else if (at_s_c)                       state_nxt = WIN_ACTIVE;
      else if (at_e_c && state == WIN_ACTIVE) state_nxt = WIN_IDLE;
    end
  end

  // Start always restarts the window, even if one is already open.
  always_comb begin
    acc_clr_c    = 1'b0;
    acc_start_c  = 1'b0;
    acc_add_c    = 1'b0;
    acc_commit_c = 1'b0;
    if (!samp_en) begin
      acc_clr_c = 1'b1;
    end else if (!cfg_bad_c) begin
      if (at_s_c) begin
        acc_start_c  = 1'b1;
        acc_commit_c = at_e_c;
      end else if (state == WIN_ACTIVE) begin
        if (at_e_c)        acc_commit_c = 1'b1;
        else if (in_mid_c) acc_add_c    = 1'b1;
      end
    end
  end

  uart_majority_acc #(
    .NSAMP(NSAMP)
  ) u_acc (
    .Clk        (Clk),
    .Rst        (Rst),
    .clr        (acc_clr_c),
    .start      (acc_start_c),
    .add        (acc_add_c),
    .din        (rx_in),
    .vote_c     (vote_c),
    .unanimous_c(unanimous_c)
  );

  // sampled_bit deliberately holds across samp_en=0.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sampled_bit <= 1'b0;
      bit_valid   <= 1'b0;
      noise_flag  <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      bit_valid <= acc_commit_c;
      cfg_err   <= cfg_err_c;
      if (acc_commit_c) begin
        sampled_bit <= vote_c;
        noise_flag  <= ~unanimous_c;
      end else if (!samp_en) begin
        noise_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed bench for uart_rx_oversampler with NSAMP=3, 5 and 7 instances
// sharing one stimulus stream.
module tb_uart_rx_oversampler;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       rx_in;
  logic       samp_en;
  logic [5:0] prescale;
  logic [5:0] edge_cnt;

  logic sb3, bv3, nf3, ce3;
  logic sb5, bv5, nf5, ce5;
  logic sb7, bv7, nf7, ce7;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  uart_rx_oversampler #(.EDGE_W(6), .NSAMP(3)) d3 (
    .Clk(Clk), .Rst(Rst), .rx_in(rx_in), .samp_en(samp_en), .prescale(prescale),
    .edge_cnt(edge_cnt), .sampled_bit(sb3), .bit_valid(bv3), .noise_flag(nf3), .cfg_err(ce3));

  uart_rx_oversampler #(.EDGE_W(6), .NSAMP(5)) d5 (
    .Clk(Clk), .Rst(Rst), .rx_in(rx_in), .samp_en(samp_en), .prescale(prescale),
    .edge_cnt(edge_cnt), .sampled_bit(sb5), .bit_valid(bv5), .noise_flag(nf5), .cfg_err(ce5));

  uart_rx_oversampler #(.EDGE_W(6), .NSAMP(7)) d7 (
    .Clk(Clk), .Rst(Rst), .rx_in(rx_in), .samp_en(samp_en), .prescale(prescale),
    .edge_cnt(edge_cnt), .sampled_bit(sb7), .bit_valid(bv7), .noise_flag(nf7), .cfg_err(ce7));

  // Apply one tick of stimulus at the falling edge; return 1 time unit after
  // the rising edge that consumed it.
  task automatic drive(input logic en, input logic rx, input int ec);
    @(negedge Clk);
    samp_en  = en;
    rx_in    = rx;
    edge_cnt = 6'(ec);
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Rst = 1'b0; rx_in = 1'b0; samp_en = 1'b0; prescale = 6'd8; edge_cnt = 6'd0;
    #2;
    total++;
    if ({sb3, bv3, nf3, ce3} !== 4'b0000) begin
      bad++; $display("FAIL reset_d3 got=%b exp=0000", {sb3, bv3, nf3, ce3});
    end
    total++;
    if ({sb7, bv7, nf7, ce7} !== 4'b0000) begin
      bad++; $display("FAIL reset_d7 got=%b exp=0000", {sb7, bv7, nf7, ce7});
    end
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    drive(1'b0, 1'b0, 0);
    total++;
    if ({bv3, ce3, ce5, ce7} !== 4'b0000) begin
      bad++; $display("FAIL post_reset_p8 got=%b exp=0000", {bv3, ce3, ce5, ce7});
    end
  endtask

  task automatic test_basic_vote;
    logic rx;
    for (int ec = 0; ec < 8; ec++) begin
      rx = (ec == 3 || ec == 5);
      drive(1'b1, rx, ec);
      total++;
      if (ec == 5) begin
        if ({bv3, sb3, nf3} !== 3'b111) begin
          bad++; $display("FAIL basic_vote ec=%0d got=%b exp=111", ec, {bv3, sb3, nf3});
        end
      end else if (bv3 !== 1'b0) begin
        bad++; $display("FAIL basic_idle ec=%0d got=%b exp=0", ec, bv3);
      end
    end
  endtask

  task automatic test_wide_prescale;
    prescale = 6'd16;
    drive(1'b0, 1'b1, 0);
    total++;
    if (ce3 !== 1'b0) begin
      bad++; $display("FAIL wide_cfg got=%b exp=0", ce3);
    end
    for (int ec = 0; ec < 16; ec++) begin
      drive(1'b1, !(ec >= 7 && ec <= 9), ec);
      if (ec == 9) begin
        total++;
        if ({bv3, sb3, nf3} !== 3'b100) begin
          bad++; $display("FAIL wide_vote got=%b exp=100", {bv3, sb3, nf3});
        end
      end else if (ec == 6 || ec == 10) begin
        total++;
        if (bv3 !== 1'b0) begin
          bad++; $display("FAIL wide_idle ec=%0d got=%b exp=0", ec, bv3);
        end
      end
    end
    prescale = 6'd8;
    drive(1'b0, 1'b0, 0);
  endtask

  task automatic test_deep_votes;
    logic [7:0] pat;
    pat = 8'b1000_1111;
    for (int ec = 0; ec < 8; ec++) begin
      drive(1'b1, pat[ec], ec);
      if (ec == 5) begin
        total++;
        if ({bv3, sb3, nf3} !== 3'b101) begin
          bad++; $display("FAIL n3_vote got=%b exp=101", {bv3, sb3, nf3});
        end
      end
      if (ec == 6) begin
        total++;
        if ({bv5, sb5, nf5, bv3} !== 4'b1010) begin
          bad++; $display("FAIL n5_vote got=%b exp=1010", {bv5, sb5, nf5, bv3});
        end
      end
      if (ec == 7) begin
        total++;
        if ({bv7, sb7, nf7} !== 3'b111) begin
          bad++; $display("FAIL n7_vote got=%b exp=111", {bv7, sb7, nf7});
        end
      end
    end
    drive(1'b0, 1'b0, 0);
  endtask

  task automatic test_cfg_err;
    total++;
    if ({ce7, ce5, ce3} !== 3'b000) begin
      bad++; $display("FAIL cfg_before got=%b exp=000", {ce7, ce5, ce3});
    end
    prescale = 6'd4;
    drive(1'b0, 1'b0, 0);
    total++;
    if ({ce7, ce5, ce3} !== 3'b110) begin
      bad++; $display("FAIL cfg_p4 got=%b exp=110", {ce7, ce5, ce3});
    end
    for (int p = 0; p < 3; p++) begin
      for (int ec = 0; ec < 4; ec++) begin
        drive(1'b1, ((ec + p) % 2) == 0, ec);
        total++;
        if ({bv7, bv5, ce7} !== 3'b001) begin
          bad++; $display("FAIL cfg_novalid p=%0d ec=%0d got=%b exp=001", p, ec, {bv7, bv5, ce7});
        end
      end
    end
    prescale = 6'd8;
    drive(1'b0, 1'b0, 0);
    total++;
    if ({ce7, ce5, ce3} !== 3'b000) begin
      bad++; $display("FAIL cfg_restore got=%b exp=000", {ce7, ce5, ce3});
    end
  endtask

  task automatic test_abort;
    for (int ec = 0; ec < 8; ec++) drive(1'b1, (ec == 3 || ec == 4), ec);
    total++;
    if ({sb3, nf3} !== 2'b11) begin
      bad++; $display("FAIL abort_prime got=%b exp=11", {sb3, nf3});
    end
    for (int ec = 0; ec < 4; ec++) drive(1'b1, 1'b1, ec);
    for (int ec = 4; ec < 8; ec++) begin
      drive(1'b0, 1'b1, ec);
      total++;
      if ({bv3, sb3, nf3} !== 3'b010) begin
        bad++; $display("FAIL abort_hold ec=%0d got=%b exp=010", ec, {bv3, sb3, nf3});
      end
    end
    for (int ec = 0; ec < 8; ec++) begin
      drive(1'b1, !(ec == 3 || ec == 5), ec);
      if (ec == 5) begin
        total++;
        if ({bv3, sb3, nf3} !== 3'b101) begin
          bad++; $display("FAIL abort_fresh got=%b exp=101", {bv3, sb3, nf3});
        end
      end
    end
  endtask

  task automatic test_restart;
    for (int ec = 0; ec < 5; ec++) drive(1'b1, (ec == 3 || ec == 4), ec);
    drive(1'b1, 1'b0, 3);
    drive(1'b1, 1'b0, 4);
    total++;
    if (bv3 !== 1'b0) begin
      bad++; $display("FAIL restart_idle got=%b exp=0", bv3);
    end
    drive(1'b1, 1'b0, 5);
    total++;
    if ({bv3, sb3, nf3} !== 3'b100) begin
      bad++; $display("FAIL restart_vote got=%b exp=100", {bv3, sb3, nf3});
    end
    drive(1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid;
    for (int ec = 0; ec < 8; ec++) drive(1'b1, (ec == 3 || ec == 5), ec);
    total++;
    if ({sb3, nf3} !== 2'b11) begin
      bad++; $display("FAIL rmid_prime got=%b exp=11", {sb3, nf3});
    end
    for (int ec = 0; ec < 5; ec++) drive(1'b1, 1'b1, ec);
    #2;
    Rst = 1'b0;
    #1;
    total++;
    if ({sb3, bv3, nf3, ce3} !== 4'b0000) begin
      bad++; $display("FAIL rmid_async got=%b exp=0000", {sb3, bv3, nf3, ce3});
    end
    @(negedge Clk);
    Rst = 1'b1;
    drive(1'b1, 1'b1, 3);
    drive(1'b1, 1'b1, 4);
    total++;
    if (bv3 !== 1'b0) begin
      bad++; $display("FAIL rmid_idle got=%b exp=0", bv3);
    end
    drive(1'b1, 1'b1, 5);
    total++;
    if ({bv3, sb3, nf3} !== 3'b110) begin
      bad++; $display("FAIL rmid_vote got=%b exp=110", {bv3, sb3, nf3});
    end
    drive(1'b1, 1'b1, 6);
    total++;
    if ({bv3, sb3} !== 2'b01) begin
      bad++; $display("FAIL rmid_strobe got=%b exp=01", {bv3, sb3});
    end
    drive(1'b0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_basic_vote();
    test_wide_prescale();
    test_deep_votes();
    test_cfg_err();
    test_abort();
    test_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
